// File: rtl/exec_unit_hs.sv
// exec_unit_hs: multi-cycle 16-bit instruction execution unit with a req/ack
// byte memory handshake, internal register file, 8-bit ALU and Z/C flags.
// Optional build macro: ILLEGAL_TRAP_EN (opcode 14 halts and raises 'illegal').
//
// state      | meaning
// -----------+------------------------------------------------------------
// FETCH_HI   | reading instruction high byte at pc (issues it after reset)
// FETCH_LO   | reading instruction low byte at pc+1
// EXECUTE    | single cycle: commit regs/flags/pc, start next fetch or data access
// MEM_WAIT   | waiting for LOAD/STORE data transaction to be acknowledged
// HALTED     | stopped; only reset leaves this state
module exec_unit_hs #(
  parameter int          NUM_REGS  = 8,
  parameter int          ADDR_BITS = 8,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic                 mem_ack,
  output logic [ADDR_BITS-1:0] pc_out,
  output logic [1:0]           flags,
  output logic                 halted
`ifdef ILLEGAL_TRAP_EN
  ,output logic                illegal
`endif
);

  typedef enum logic [2:0] {
    S_FETCH_HI,
    S_FETCH_LO,
    S_EXECUTE,
    S_MEM_WAIT,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_MOVI  = 4'd1;
  localparam logic [3:0] OP_MOV   = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_ADDI  = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_SUBI  = 4'd8;
  localparam logic [3:0] OP_JZ    = 4'd9;
  localparam logic [3:0] OP_JZR   = 4'd10;
  localparam logic [3:0] OP_JC    = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;
  localparam logic [3:0] OP_CMP   = 4'd13;
  localparam logic [3:0] OP_ILL   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  // ir is kept as its decoded fields; bit 11 of the instruction carries nothing
  logic [3:0]             ir_op_q, ir_op_d;
  logic [2:0]             ir_rd_q, ir_rd_d;
  logic [7:0]             ir_imm_q, ir_imm_d;
  logic [7:0]             regs_q [NUM_REGS];
  logic [7:0]             regs_d [NUM_REGS];
  logic [1:0]             flags_q, flags_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;
  logic                   halted_q, halted_d;
`ifdef ILLEGAL_TRAP_EN
  logic                   illegal_q, illegal_d;
`endif

  logic [2:0]             ra_idx, rb_idx;
  logic [7:0]             rd_val, ra_val, rb_val;
  logic                   is_rr;
  logic [7:0]             alu_a, alu_b;
  logic [8:0]             sum_w, diff_w;
  logic [ADDR_BITS-1:0]   pc_plus1, pc_plus2, imm_ext, rd_ext;
  logic                   wr_en;
  logic [7:0]             wr_val;
  logic                   fetch_en;
  logic [ADDR_BITS-1:0]   fetch_addr;

  assign ra_idx   = ir_imm_q[6:4];
  assign rb_idx   = ir_imm_q[2:0];
  assign pc_plus1 = pc_q + ADDR_BITS'(1);
  assign pc_plus2 = pc_q + ADDR_BITS'(2);
  assign imm_ext  = ADDR_BITS'(ir_imm_q);
  assign rd_ext   = ADDR_BITS'(rd_val);

  // Register-file read ports; indices beyond NUM_REGS read as zero.
  always_comb begin
    rd_val = '0;
    ra_val = '0;
    rb_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ir_rd_q == 3'(i)) rd_val = regs_q[i];
      if (ra_idx == 3'(i))  ra_val = regs_q[i];
      if (rb_idx == 3'(i))  rb_val = regs_q[i];
    end
  end

  // Shared ALU: register-register forms use ra/rb, immediate forms use rd/imm.
  always_comb begin
    is_rr  = (ir_op_q == OP_ADD) || (ir_op_q == OP_SUB) || (ir_op_q == OP_CMP);
    alu_a  = is_rr ? ra_val : rd_val;
    alu_b  = is_rr ? rb_val : ir_imm_q;
    sum_w  = {1'b0, alu_a} + {1'b0, alu_b};
    diff_w = {1'b0, alu_a} - {1'b0, alu_b};
  end

  // Sequencer: next state, handshake, execute-stage commits.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_op_d     = ir_op_q;
    ir_rd_d     = ir_rd_q;
    ir_imm_d    = ir_imm_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    mem_req_d   = mem_req_q & ~mem_ack;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    wr_en       = 1'b0;
    wr_val      = '0;
    fetch_en    = 1'b0;
    fetch_addr  = pc_q;

    case (state_q)
      S_FETCH_HI: begin
        if (!mem_req_q) begin
          // only reached straight out of reset: nothing in flight yet
          fetch_en   = 1'b1;
          fetch_addr = pc_q;
        end else if (mem_ack) begin
          ir_op_d    = mem_rdata[7:4];
          ir_rd_d    = mem_rdata[2:0];
          fetch_en   = 1'b1;
          fetch_addr = pc_plus1;
          state_d    = S_FETCH_LO;
        end
      end
      S_FETCH_LO: begin
        if (mem_req_q && mem_ack) begin
          ir_imm_d = mem_rdata;
          state_d  = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        pc_d     = pc_plus2;
        fetch_en = 1'b1;
        state_d  = S_FETCH_HI;
        case (ir_op_q)
          OP_MOVI: begin
            wr_en  = 1'b1;
            wr_val = ir_imm_q;
          end
          OP_MOV: begin
            wr_en  = 1'b1;
            wr_val = ra_val;
          end
          OP_LOAD, OP_STORE: begin
            pc_d        = pc_q;
            fetch_en    = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = (ir_op_q == OP_STORE);
            mem_addr_d  = imm_ext;
            mem_wdata_d = rd_val;
            state_d     = S_MEM_WAIT;
          end
          OP_ADD, OP_ADDI: begin
            wr_en   = 1'b1;
            wr_val  = sum_w[7:0];
            flags_d = {sum_w[8], sum_w[7:0] == 8'h00};
          end
          OP_SUB, OP_SUBI, OP_CMP: begin
            // carry means "no borrow"
            wr_en   = (ir_op_q != OP_CMP);
            wr_val  = diff_w[7:0];
            flags_d = {~diff_w[8], diff_w[7:0] == 8'h00};
          end
          OP_JZ:  if (flags_q[0]) pc_d = imm_ext;
          OP_JZR: if (flags_q[0]) pc_d = rd_ext;
          OP_JC:  if (flags_q[1]) pc_d = imm_ext;
          OP_JMP: pc_d = imm_ext;
`ifdef ILLEGAL_TRAP_EN
          OP_ILL: begin
            pc_d      = pc_q;
            fetch_en  = 1'b0;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = S_HALTED;
          end
`endif
          OP_HALT: begin
            pc_d     = pc_q;
            fetch_en = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end
          default: ;
        endcase
        fetch_addr = pc_d;
      end
      S_MEM_WAIT: begin
        if (mem_req_q && mem_ack) begin
          wr_en      = ~mem_we_q;
          wr_val     = mem_rdata;
          pc_d       = pc_plus2;
          fetch_en   = 1'b1;
          fetch_addr = pc_plus2;
          state_d    = S_FETCH_HI;
        end
      end
      S_HALTED: begin
        mem_req_d = 1'b0;
      end
      default: state_d = S_FETCH_HI;
    endcase

    if (fetch_en) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = fetch_addr;
    end

    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (ir_rd_q == 3'(i))) regs_d[i] = wr_val;
    end
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH_HI;
      pc_q        <= ADDR_BITS'(RESET_PC);
      ir_op_q     <= '0;
      ir_rd_q     <= '0;
      ir_imm_q    <= '0;
      regs_q      <= '{default: '0};
      flags_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_op_q     <= ir_op_d;
      ir_rd_q     <= ir_rd_d;
      ir_imm_q    <= ir_imm_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign pc_out    = pc_q;
  assign flags     = flags_q;
  assign halted    = halted_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_exec_unit_hs.sv
// tb_exec_unit_hs: memory responder with random wait states and spurious acks,
// instruction-level reference model, directed and random programs.
module tb_exec_unit_hs;

  localparam int NREGS = 8;
  localparam int RPC   = 0;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic       mem_req, mem_we, mem_ack, halted;
  logic [1:0] flags;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  exec_unit_hs #(.NUM_REGS(NREGS), .ADDR_BITS(8), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .pc_out(pc_out), .flags(flags), .halted(halted)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [256];
  logic [7:0] mdl_mem [256];
  logic [7:0] m_r [8];
  txn_t exp_q[$];
  txn_t obs_q[$];
  int   exp_cycles, exp_illegal, last_cycles;
  logic [7:0] exp_pc;
  logic [1:0] exp_flags;

  bit   resp_en = 1'b0;
  bit   new_txn = 1'b1;
  bit   ack_pending = 1'b0;
  int   waits_left, fixed_wait, max_wait, total_waits;
  logic [7:0] cur_addr, cur_wdata;
  logic       cur_we;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: random wait states, checks signals held while waiting.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        mem_ack = 1'b0;
        ack_pending = 1'b0;
        new_txn = 1'b1;
      end else begin
        if (ack_pending) begin
          ack_pending = 1'b0;
          new_txn = 1'b1;
        end
        mem_ack = 1'b0;
        if (mem_req) begin
          if (new_txn) begin
            new_txn = 1'b0;
            cur_addr = mem_addr; cur_we = mem_we; cur_wdata = mem_wdata;
            waits_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
            total_waits += waits_left;
          end else begin
            check_val("hold_addr", mem_addr, cur_addr);
            check_val("hold_we", mem_we, cur_we);
            check_val("hold_wdata", mem_wdata, cur_wdata);
          end
          if (waits_left == 0) begin
            txn_t t;
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
            t.addr = mem_addr; t.we = mem_we; t.wdata = mem_wdata;
            obs_q.push_back(t);
            ack_pending = 1'b1;
          end else begin
            waits_left--;
            mem_rdata = 8'($urandom);
          end
        end else begin
          if (!new_txn) begin
            check_val("req_held", 0, 1);
            new_txn = 1'b1;
          end
          mem_ack = ($urandom_range(0, 3) == 0);
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rget(input int idx);
    return (idx < NREGS) ? m_r[idx] : 8'h00;
  endfunction

  task automatic rset(input int idx, input logic [7:0] v);
    if (idx < NREGS) m_r[idx] = v;
  endtask

  task automatic push_txn(input logic [7:0] a, input logic we, input logic [7:0] d);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = d;
    exp_q.push_back(t);
  endtask

  // Instruction-level model: walks the program and records expected bus traffic.
  task automatic run_model();
    logic [7:0] pc, npc, imm;
    logic [15:0] ir;
    logic c, z;
    int op, rd, ra, rb, a, b, s;
    exp_q.delete();
    exp_cycles = 0;
    exp_illegal = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    pc = 8'(RPC); c = 1'b0; z = 1'b0;
    for (int step = 0; step < 2000; step++) begin
      push_txn(pc, 1'b0, 8'h00);
      push_txn(pc + 8'd1, 1'b0, 8'h00);
      ir = {mdl_mem[pc], mdl_mem[pc + 8'd1]};
      op = int'(ir[15:12]); rd = int'(ir[10:8]); ra = int'(ir[6:4]); rb = int'(ir[2:0]);
      imm = ir[7:0];
      exp_cycles += 3;
      if (op == 15 || (op == 14 && TRAP)) begin
        if (op == 14) exp_illegal = 1;
        break;
      end
      npc = pc + 8'd2;
      case (op)
        1: rset(rd, imm);
        2: rset(rd, rget(ra));
        3: begin push_txn(imm, 1'b0, 8'h00); rset(rd, mdl_mem[imm]); exp_cycles += 1; end
        4: begin push_txn(imm, 1'b1, rget(rd)); mdl_mem[imm] = rget(rd); exp_cycles += 1; end
        5, 6: begin
          a = int'(op == 5 ? rget(ra) : rget(rd));
          b = int'(op == 5 ? rget(rb) : imm);
          s = a + b;
          c = (s > 255); z = ((s % 256) == 0);
          rset(rd, 8'(s % 256));
        end
        7, 8, 13: begin
          a = int'(op == 8 ? rget(rd) : rget(ra));
          b = int'(op == 8 ? imm : rget(rb));
          s = (a - b + 256) % 256;
          c = (a >= b); z = (s == 0);
          if (op != 13) rset(rd, 8'(s));
        end
        9:  if (z) npc = imm;
        10: if (z) npc = rget(rd);
        11: if (c) npc = imm;
        12: npc = imm;
        default: ;
      endcase
      pc = npc;
    end
    exp_pc = pc;
    exp_flags = {c, z};
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      mdl_mem[i] = mem[i];
    end
  endtask

  task automatic put_word(input logic [7:0] a, input logic [15:0] w);
    mem[a] = w[15:8]; mem[a + 8'd1] = w[7:0];
    mdl_mem[a] = w[15:8]; mdl_mem[a + 8'd1] = w[7:0];
  endtask

  task automatic run_prog(input string name, input int fw, input int mw);
    int t0, t1, n;
    bit started, done;
    resp_en = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val({name, ":rst_req"}, mem_req, 0);
    check_val({name, ":rst_we"}, mem_we, 0);
    check_val({name, ":rst_addr"}, mem_addr, 0);
    check_val({name, ":rst_wdata"}, mem_wdata, 0);
    check_val({name, ":rst_halted"}, halted, 0);
    check_val({name, ":rst_flags"}, flags, 0);
    check_val({name, ":rst_pc"}, pc_out, RPC);
    run_model();
    obs_q.delete();
    total_waits = 0; fixed_wait = fw; max_wait = mw;
    reset_n = 1'b1;
    resp_en = 1'b1;
    started = 0; done = 0; t0 = 0; t1 = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (!started && mem_req) begin started = 1; t0 = cyc; end
      if (halted) begin done = 1; t1 = cyc; end
    end
    check_val({name, ":halt_seen"}, done, 1);
    last_cycles = t1 - t0;
    check_val({name, ":cycles"}, last_cycles, exp_cycles + total_waits);
    check_val({name, ":pc_out"}, pc_out, exp_pc);
    check_val({name, ":flags"}, flags, exp_flags);
`ifdef ILLEGAL_TRAP_EN
    check_val({name, ":illegal"}, illegal, exp_illegal);
`endif
    check_val({name, ":txn_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s:txn%0d_addr", name, i), obs_q[i].addr, exp_q[i].addr);
      check_val($sformatf("%s:txn%0d_we", name, i), obs_q[i].we, exp_q[i].we);
      if (exp_q[i].we) check_val($sformatf("%s:txn%0d_wdata", name, i), obs_q[i].wdata, exp_q[i].wdata);
    end
    repeat (5) @(negedge clk);
    check_val({name, ":halt_req"}, mem_req, 0);
    check_val({name, ":halt_pc"}, pc_out, exp_pc);
    check_val({name, ":halt_hold"}, halted, 1);
  endtask

  task automatic load_t1();
    clear_mem();
    put_word(8'h00, 16'h1105);
    put_word(8'h02, 16'h1203);
    put_word(8'h04, 16'h7312);
    put_word(8'h06, 16'hF000);
  endtask

  initial begin
    bit found;
    int ops[11];
    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 13, 14};

    // T1: MOVI/MOVI/SUB/HALT, zero wait states
    load_t1();
    run_prog("t1", 0, 0);
    check_val("t1:cycles_12", last_cycles, 12);
    check_val("t1:pc_06", pc_out, 8'h06);
    check_val("t1:flags_c1z0", flags, 2'b10);

    // T1b: same with r3 stored, 3 wait states per transaction
    clear_mem();
    put_word(8'h00, 16'h1105);
    put_word(8'h02, 16'h1203);
    put_word(8'h04, 16'h7312);
    put_word(8'h06, 16'h43C3);
    put_word(8'h08, 16'hF000);
    run_prog("t1w", 3, 0);
    check_val("t1w:r3", mem[8'hC3], 8'h02);
    check_val("t1w:flags_c1z0", flags, 2'b10);

    // T2: store then load back
    clear_mem();
    put_word(8'h00, 16'h10AA);
    put_word(8'h02, 16'h4040);
    put_word(8'h04, 16'h3440);
    put_word(8'h06, 16'h44C4);
    put_word(8'h08, 16'hF000);
    run_prog("t2", -1, 2);
    if (obs_q.size() > 4) begin
      check_val("t2:wr_addr", obs_q[4].addr, 8'h40);
      check_val("t2:wr_we", obs_q[4].we, 1);
      check_val("t2:wr_data", obs_q[4].wdata, 8'hAA);
    end
    check_val("t2:r4", mem[8'hC4], 8'hAA);

    // T3: overflow to zero, JZ taken / not taken
    clear_mem();
    put_word(8'h00, 16'h11FF);
    put_word(8'h02, 16'h6101);
    put_word(8'h04, 16'h9020);
    put_word(8'h06, 16'hF000);
    put_word(8'h20, 16'h41C1);
    put_word(8'h22, 16'hF000);
    run_prog("t3z", 0, 0);
    if (obs_q.size() > 6) check_val("t3z:target", obs_q[6].addr, 8'h20);
    check_val("t3z:flags_c1z1", flags, 2'b11);
    check_val("t3z:r1", mem[8'hC1], 8'h00);
    put_word(8'h02, 16'h6100);
    run_prog("t3n", 0, 0);
    if (obs_q.size() > 6) check_val("t3n:fallthru", obs_q[6].addr, 8'h06);
    check_val("t3n:flags_c0z0", flags, 2'b00);

    // T4: JMP to FE, pc wraps to 0 after NOP-like SUBI at FE, then JC taken
    clear_mem();
    put_word(8'h00, 16'hB008);
    put_word(8'h02, 16'hC0FE);
    put_word(8'hFE, 16'h8700);
    put_word(8'h08, 16'hF000);
    run_prog("t4", -1, 1);
    if (obs_q.size() > 6) check_val("t4:wrap", obs_q[6].addr, 8'h00);

    // T5: CMP sets Z, JZR jumps via register
    clear_mem();
    put_word(8'h00, 16'h1510);
    put_word(8'h02, 16'hD055);
    put_word(8'h04, 16'hA500);
    put_word(8'h06, 16'hF000);
    put_word(8'h10, 16'hF000);
    run_prog("t5", 0, 0);
    check_val("t5:pc_10", pc_out, 8'h10);

    // T6: opcode 14
    clear_mem();
    put_word(8'h00, 16'hE000);
    put_word(8'h02, 16'h1107);
    put_word(8'h04, 16'hF000);
    run_prog("t6", 0, 0);
`ifdef ILLEGAL_TRAP_EN
    check_val("t6:trap_pc", pc_out, 8'h00);
    check_val("t6:trap_flag", illegal, 1);
`else
    check_val("t6:nop_pc", pc_out, 8'h04);
`endif

    // T7: reset asserted during the second fetch's wait
    load_t1();
    resp_en = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    fixed_wait = 5; max_wait = 0; total_waits = 0;
    reset_n = 1'b1;
    resp_en = 1'b1;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h01) found = 1;
    end
    check_val("t7:second_fetch", found, 1);
    @(negedge clk);
    #2;
    resp_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check_val("t7:req_drop", mem_req, 0);
    check_val("t7:addr_clr", mem_addr, 0);
    run_prog("t7", 0, 0);
    if (obs_q.size() > 0) check_val("t7:restart_pc", obs_q[0].addr, RPC);

    // Random straight-line programs with forward branches
    for (int r = 0; r < 6; r++) begin
      int nins;
      logic [15:0] w;
      nins = 16;
      clear_mem();
      for (int i = 0; i < nins; i++) begin
        int op;
        op = ops[$urandom_range(0, 10)];
        w = 16'($urandom);
        w[15:12] = 4'(op);
        if (op == 3 || op == 4) w[7:0] = 8'(8'h80 + $urandom_range(0, 63));
        if ($urandom_range(0, 5) == 0) begin
          w[15:12] = 4'($urandom_range(9, 12) == 10 ? 12 : $urandom_range(9, 12));
          if (w[15:12] == 4'd10) w[15:12] = 4'd9;
          w[7:0] = 8'(2 * $urandom_range(i + 1, nins));
        end
        put_word(8'(2 * i), w);
      end
      for (int k = 0; k < 8; k++) put_word(8'(2 * (nins + k)), 16'h40C0 | 16'(k << 8) | 16'(k));
      put_word(8'(2 * (nins + 8)), 16'hF000);
      run_prog($sformatf("rnd%0d", r), -1, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
